// File: rtl/booth_sched_pkg.sv
// booth_sched_pkg: shared state encoding and sizing helper for the Booth multiplier scheduler
package booth_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;
  function automatic int wdog_w(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the slot after last
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        found = 1'b1;
        grant[(int'(last) + k) % N] = 1'b1;
        idx = IW'((int'(last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/booth_mult_scheduler.sv
// booth_mult_scheduler: round-robin sharing of one sequential signed multiplier with a watchdog
module booth_mult_scheduler
  import booth_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [2*W-1:0]           rsp_result,
  output logic                     rsp_err,
  output logic                     mul_start,
  output logic [W-1:0]             mul_a,
  output logic [W-1:0]             mul_b,
  input  logic [2*W-1:0]           mul_result,
  input  logic                     mul_done
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = wdog_w(TIMEOUT);
  state_t state_q, state_d;
  logic [ID_W-1:0] last_q, last_d, id_q, id_d, grant_idx;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [2*W-1:0] res_q, res_d;
  logic err_q, err_d;
  logic [N_REQ-1:0] grant;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant),
    .idx   (grant_idx)
  );
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    wdog_d = wdog_q;
    res_d = res_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = START;
        last_d = grant_idx;
        id_d = grant_idx;
        a_d = req_a[int'(grant_idx)*W +: W];
        b_d = req_b[int'(grant_idx)*W +: W];
      end
      START: begin
        wdog_d = '0;
        state_d = BUSY;
      end
      // wdog==0 marks the first BUSY cycle, where mul_done may still reflect the previous job
      BUSY: if (wdog_q != '0 && mul_done) begin
        res_d = mul_result;
        err_d = 1'b0;
        state_d = RESP;
      end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
        res_d = '0;
        err_d = 1'b1;
        state_d = RESP;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= ID_W'(N_REQ - 1);
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      wdog_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      wdog_q <= wdog_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end
  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign mul_start = state_q == START;
  assign mul_a = a_q;
  assign mul_b = b_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_result = res_q;
  assign rsp_err = err_q;
endmodule
